// File: rtl/keypad_scan_param.sv
// keypad_scan_param
// Scans an NROWS x NCOLS matrix keypad by driving one column low at a time
// and watching the (pulled-up, active-low) row lines. A detected key is
// debounced, reported once as a key event, optionally auto-repeated while
// held, and debounced again on release before scanning resumes.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : synchronous, active-high
//   rows       : row lines, active low (asynchronous to clk)
//   cols       : column drive, scanned column low, others high
//   key_valid  : one-cycle pulse per key event
//   key_code   : row*NCOLS+col of the last event, held between events
//   key_repeat : qualifies key_valid; 1 = auto-repeat event
//   key_held   : high while a debounced key is held (including release debounce)
//   last_key   : most recent non-repeat key code
//   prev_key   : non-repeat key code before last_key
module keypad_scan_param #(
  parameter int NROWS           = 4,
  parameter int NCOLS           = 4,
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_CYCLES   = 64,
  localparam int KW = ($clog2(NROWS*NCOLS) < 1) ? 1 : $clog2(NROWS*NCOLS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NROWS-1:0] rows,
  output logic [NCOLS-1:0] cols,
  output logic             key_valid,
  output logic [KW-1:0]    key_code,
  output logic             key_repeat,
  output logic             key_held,
  output logic [KW-1:0]    last_key,
  output logic [KW-1:0]    prev_key
);

  localparam int RW = ($clog2(NROWS) < 1)           ? 1 : $clog2(NROWS);
  localparam int CW = ($clog2(NCOLS) < 1)           ? 1 : $clog2(NCOLS);
  localparam int DW = ($clog2(SCAN_CYCLES) < 1)     ? 1 : $clog2(SCAN_CYCLES);
  localparam int BW = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam int PW = ($clog2(REPEAT_CYCLES) < 1)   ? 1 : $clog2(REPEAT_CYCLES);

  localparam logic [CW-1:0] COL_LAST   = CW'(NCOLS - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);
  // The HELD cycle that first sees the row high already counts as one of
  // the release samples, so RELEASE itself needs one fewer.
  localparam logic [BW-1:0] REL_LAST   = BW'((DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0);
  localparam logic [PW-1:0] RPT_LAST   = PW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [NROWS-1:0] sync1_q, sync2_q;
  logic [CW-1:0]   col_idx_q, col_idx_d;
  logic [RW-1:0]   row_idx_q, row_idx_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [BW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   rpt_q, rpt_d;
  logic            key_valid_q, key_valid_d;
  logic            key_repeat_q, key_repeat_d;
  logic            key_held_q, key_held_d;
  logic [KW-1:0]   key_code_q, key_code_d;
  logic [KW-1:0]   last_key_q, last_key_d;
  logic [KW-1:0]   prev_key_q, prev_key_d;

  logic            low_found;
  logic [RW-1:0]   low_row;
  logic            locked_low;
  logic [KW-1:0]   new_code;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= '1;
      sync2_q      <= '1;
      state_q      <= SCAN;
      col_idx_q    <= '0;
      row_idx_q    <= '0;
      dwell_q      <= '0;
      cnt_q        <= '0;
      rpt_q        <= '0;
      key_valid_q  <= 1'b0;
      key_repeat_q <= 1'b0;
      key_held_q   <= 1'b0;
      key_code_q   <= '0;
      last_key_q   <= '0;
      prev_key_q   <= '0;
    end else begin
      sync1_q      <= rows;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      col_idx_q    <= col_idx_d;
      row_idx_q    <= row_idx_d;
      dwell_q      <= dwell_d;
      cnt_q        <= cnt_d;
      rpt_q        <= rpt_d;
      key_valid_q  <= key_valid_d;
      key_repeat_q <= key_repeat_d;
      key_held_q   <= key_held_d;
      key_code_q   <= key_code_d;
      last_key_q   <= last_key_d;
      prev_key_q   <= prev_key_d;
    end
  end

  // Lowest-index row currently reading low.
  always_comb begin
    low_found = 1'b0;
    low_row   = '0;
    for (int unsigned r = 0; r < NROWS; r++) begin
      if (!sync2_q[r] && !low_found) begin
        low_found = 1'b1;
        low_row   = RW'(r);
      end
    end
  end

  assign locked_low = ~sync2_q[row_idx_q];
  assign new_code   = KW'(int'(row_idx_q) * NCOLS + int'(col_idx_q));

  always_comb begin
    state_d      = state_q;
    col_idx_d    = col_idx_q;
    row_idx_d    = row_idx_q;
    dwell_d      = dwell_q;
    cnt_d        = cnt_q;
    rpt_d        = rpt_q;
    key_valid_d  = 1'b0;
    key_repeat_d = 1'b0;
    key_code_d   = key_code_q;
    last_key_d   = last_key_q;
    prev_key_d   = prev_key_q;

    case (state_q)
      SCAN: begin
        // Rows are only sampled on the last dwell cycle, after the new
        // column drive has had time to pass through the synchronizer.
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (low_found) begin
            row_idx_d = low_row;
            cnt_d     = '0;
            state_d   = DEBOUNCE;
          end else begin
            col_idx_d = (col_idx_q == COL_LAST) ? '0 : col_idx_q + 1'b1;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end

      DEBOUNCE: begin
        if (!locked_low) begin
          state_d = SCAN;
          dwell_d = '0;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d     = HELD;
          cnt_d       = '0;
          rpt_d       = '0;
          key_valid_d = 1'b1;
          key_code_d  = new_code;
          last_key_d  = new_code;
          prev_key_d  = last_key_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      HELD: begin
        if (!locked_low) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end else if (REPEAT_EN != 0) begin
          if (rpt_q == RPT_LAST) begin
            rpt_d        = '0;
            key_valid_d  = 1'b1;
            key_repeat_d = 1'b1;
            key_code_d   = new_code;
          end else begin
            rpt_d = rpt_q + 1'b1;
          end
        end
      end

      RELEASE: begin
        // rpt_q is left untouched here so a bounce back to HELD resumes
        // the repeat interval rather than restarting it.
        if (locked_low) begin
          state_d = HELD;
        end else if (cnt_q == REL_LAST) begin
          state_d   = SCAN;
          col_idx_d = '0;
          dwell_d   = '0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = SCAN;
    endcase

    key_held_d = (state_d == HELD) || (state_d == RELEASE);
  end

  always_comb begin
    cols            = '1;
    cols[col_idx_q] = 1'b0;
  end

  assign key_valid  = key_valid_q;
  assign key_repeat = key_repeat_q;
  assign key_held   = key_held_q;
  assign key_code   = key_code_q;
  assign last_key   = last_key_q;
  assign prev_key   = prev_key_q;

endmodule

// File: tb/tb_keypad_scan_param.sv
// tb_keypad_scan_param
// Drives two 4x4 keypad scanners (auto-repeat off and on) from a simple
// switch-matrix model and compares the reported key events against a
// behavioural expectation of codes, last/prev history and repeat timing.
module tb_keypad_scan_param;

  localparam int LAT_MAX = 2 + 4 * 4 + 8;
  localparam int REL_MAX = 2 + 8;

  typedef struct {
    int code;
    int rpt;
    int cyc;
    int last;
    int prev;
  } ev_t;

  logic       clk;
  logic       reset;
  logic [15:0] keys_a, keys_b;
  logic [3:0] rows_a, rows_b, cols_a, cols_b;
  logic       kv_a, kr_a, kh_a, kv_b, kr_b, kh_b;
  logic [3:0] kc_a, lk_a, pk_a, kc_b, lk_b, pk_b;
  logic [3:0] kc_a_prev, kc_b_prev;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   viol_rpt = 0;
  int   viol_hold = 0;
  int   mlast[2];
  int   mprev[2];
  ev_t  ev_a[$];
  ev_t  ev_b[$];

  keypad_scan_param dut_a (
    .clk(clk), .reset(reset), .rows(rows_a), .cols(cols_a),
    .key_valid(kv_a), .key_code(kc_a), .key_repeat(kr_a), .key_held(kh_a),
    .last_key(lk_a), .prev_key(pk_a)
  );

  keypad_scan_param #(.REPEAT_EN(1), .REPEAT_CYCLES(64)) dut_b (
    .clk(clk), .reset(reset), .rows(rows_b), .cols(cols_b),
    .key_valid(kv_b), .key_code(kc_b), .key_repeat(kr_b), .key_held(kh_b),
    .last_key(lk_b), .prev_key(pk_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Switch matrix: a row reads low when a pressed key sits on a driven column.
  always_comb begin
    rows_a = '1;
    rows_b = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (keys_a[r*4+c] && !cols_a[c]) rows_a[r] = 1'b0;
        if (keys_b[r*4+c] && !cols_b[c]) rows_b[r] = 1'b0;
      end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (kv_a) ev_a.push_back('{int'(kc_a), int'(kr_a), cyc, int'(lk_a), int'(pk_a)});
      if (kv_b) ev_b.push_back('{int'(kc_b), int'(kr_b), cyc, int'(lk_b), int'(pk_b)});
      if ((kr_a && !kv_a) || (kr_b && !kv_b)) viol_rpt <= viol_rpt + 1;
      if ((!kv_a && kc_a != kc_a_prev) || (!kv_b && kc_b != kc_b_prev)) viol_hold <= viol_hold + 1;
    end
    kc_a_prev <= kc_a;
    kc_b_prev <= kc_b;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, got unfinished run, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic held(input int sel);
    return (sel != 0) ? kh_b : kh_a;
  endfunction

  task automatic set_key(input int sel, input int r, input int c, input logic v);
    if (sel != 0) keys_b[r*4+c] = v;
    else          keys_a[r*4+c] = v;
  endtask

  // Counts rising edges until key_held reaches lvl (bounded).
  task automatic wait_held(input int sel, input logic lvl, output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (held(sel) !== lvl && n < 300);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_cols", cols_a, 4'b1110);
    reset = 1'b0;
    mlast = '{0, 0};
    mprev = '{0, 0};
    ev_a.delete();
    ev_b.delete();
  endtask

  task automatic press_key(input int sel, input int r, input int c, input int hold);
    int n;
    @(posedge clk);
    #1 set_key(sel, r, c, 1'b1);
    wait_held(sel, 1'b1, n);
    check("press_latency_ok", n <= LAT_MAX, 1);
    repeat (hold) @(posedge clk);
    #1 set_key(sel, r, c, 1'b0);
    wait_held(sel, 1'b0, n);
    check("release_latency_ok", n <= REL_MAX, 1);
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic bounce(input int sel, input int r, input int c, input int len);
    logic       seen_held;
    logic [3:0] seen_cols;
    @(posedge clk);
    #1 set_key(sel, r, c, 1'b1);
    repeat (len) @(posedge clk);
    #1 set_key(sel, r, c, 1'b0);
    seen_held = 1'b0;
    seen_cols = '0;
    repeat (40) begin
      @(negedge clk);
      if (held(sel)) seen_held = 1'b1;
      for (int i = 0; i < 4; i++)
        if (!((sel != 0) ? cols_b[i] : cols_a[i])) seen_cols[i] = 1'b1;
    end
    check("bounce_no_held", seen_held, 1'b0);
    check("bounce_no_event", (sel != 0) ? ev_b.size() : ev_a.size(), 0);
    check("bounce_scan_resumes", seen_cols, 4'hF);
    @(posedge clk);
    #1;
  endtask

  // One accepted press of code, followed by nrpt auto-repeats 64 cycles apart.
  task automatic expect_press(input int sel, input int code, input int nrpt);
    ev_t q[$];
    q = (sel != 0) ? ev_b : ev_a;
    mprev[sel] = mlast[sel];
    mlast[sel] = code;
    check("event_count", q.size(), 1 + nrpt);
    if (q.size() > 0) begin
      check("event_code", q[0].code, code);
      check("event_is_first", q[0].rpt, 0);
      check("event_last", q[0].last, mlast[sel]);
      check("event_prev", q[0].prev, mprev[sel]);
    end
    for (int i = 1; i < q.size(); i++) begin
      check("repeat_flag", q[i].rpt, 1);
      check("repeat_code", q[i].code, code);
      check("repeat_spacing", q[i].cyc - q[i-1].cyc, 64);
      check("repeat_last", q[i].last, mlast[sel]);
      check("repeat_prev", q[i].prev, mprev[sel]);
    end
    check("port_key_code", (sel != 0) ? kc_b : kc_a, code);
    check("port_last_key", (sel != 0) ? lk_b : lk_a, mlast[sel]);
    check("port_prev_key", (sel != 0) ? pk_b : pk_a, mprev[sel]);
    if (sel != 0) ev_b.delete();
    else          ev_a.delete();
  endtask

  initial begin
    int         n, r, c;
    logic [3:0] ecols;

    reset  = 1'b1;
    keys_a = '0;
    keys_b = '0;

    // Reset state and idle scan pattern
    do_reset();
    check("reset_outputs_a", {kv_a, kr_a, kh_a, kc_a, lk_a, pk_a}, 0);
    check("reset_outputs_b", {kv_b, kr_b, kh_b, kc_b, lk_b, pk_b}, 0);
    check("reset_cols_b", cols_b, 4'b1110);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ecols = 4'hF;
      ecols[(i / 4) % 4] = 1'b0;
      check("scan_cols", cols_a, ecols);
    end
    check("idle_outputs", {kv_a, kr_a, kh_a, kc_a, lk_a, pk_a}, 0);
    @(posedge clk);
    #1;

    // Long press at (1,2)
    press_key(0, 1, 2, 500);
    expect_press(0, 6, 0);

    // Short bounce at (2,1)
    bounce(0, 2, 1, 3);

    // Two presses in sequence
    press_key(0, 1, 2, 40);
    expect_press(0, 6, 0);
    press_key(0, 2, 1, 40);
    expect_press(0, 9, 0);

    // Reset during debounce aborts without an event and clears history
    do_reset();
    @(posedge clk);
    #1 keys_a[0] = 1'b1;
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    keys_a = '0;
    reset  = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("abort_no_event", ev_a.size(), 0);
    check("abort_outputs", {kh_a, lk_a, pk_a}, 0);

    // Second key while one is held: ignored, scan restarts at column 0
    @(posedge clk);
    #1 keys_a[1*4+2] = 1'b1;
    wait_held(0, 1'b1, n);
    check("multikey_press_latency_ok", n <= LAT_MAX, 1);
    repeat (20) @(posedge clk);
    #1 keys_a[3*4+2] = 1'b1;
    repeat (60) @(posedge clk);
    #1 keys_a = '0;
    wait_held(0, 1'b0, n);
    check("multikey_release_latency_ok", n <= REL_MAX, 1);
    check("multikey_resume_col0", cols_a, 4'b1110);
    repeat (10) @(posedge clk);
    #1;
    expect_press(0, 6, 0);

    // Random presses and bounces
    for (int it = 0; it < 14; it++) begin
      r = int'($urandom_range(0, 3));
      c = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        bounce(0, r, c, int'($urandom_range(1, 3)));
      end else begin
        press_key(0, r, c, int'($urandom_range(5, 300)));
        expect_press(0, r * 4 + c, 0);
      end
    end

    // Auto-repeat instance
    check("rpt_idle_no_event", ev_b.size(), 0);
    press_key(1, 2, 3, 30);
    expect_press(1, 11, 0);
    press_key(1, 0, 0, 200);
    expect_press(1, 0, 3);
    r = int'($urandom_range(0, 3));
    c = int'($urandom_range(0, 3));
    n = int'($urandom_range(1, 2));
    press_key(1, r, c, 64 * n + 10 + int'($urandom_range(0, 40)));
    expect_press(1, r * 4 + c, n);

    check("no_stray_repeat", viol_rpt, 0);
    check("key_code_holds", viol_hold, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scan_param.md
KEYPAD_SCAN_PARAM -- requirements
Module: keypad_scan_param

Interface
REQ-001 SHALL have parameter NROWS, default 4: number of keypad rows.
REQ-002 SHALL have parameter NCOLS, default 4: number of keypad columns.
REQ-003 SHALL have parameter SCAN_CYCLES, default 4: clock cycles each column is driven during scan (>=3).
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 8: consecutive stable samples needed to accept a press or a release.
REQ-005 SHALL have parameter REPEAT_EN, default 0: 1 enables auto-repeat while a key is held.
REQ-006 SHALL have parameter REPEAT_CYCLES, default 64: held cycles between auto-repeat events.
REQ-007 SHALL derive localparam KW = clog2(NROWS*NCOLS), with a minimum of 1.
REQ-008 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-009 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-010 SHALL have port rows  input  NROWS  row lines, active low, externally pulled up.
REQ-011 SHALL have port cols  output  NCOLS  column drive; the scanned column is low, all others high.
REQ-012 SHALL have port key_valid  output  1  one-cycle pulse per accepted key event.
REQ-013 SHALL have port key_code  output  KW  code of the last event: row*NCOLS+col.
REQ-014 SHALL have port key_repeat  output  1  qualifies key_valid; 1 = auto-repeat event.
REQ-015 SHALL have port key_held  output  1  high while a debounced key is held.
REQ-016 SHALL have port last_key  output  KW  most recent non-repeat key code (display digit 0).
REQ-017 SHALL have port prev_key  output  KW  previous non-repeat key code (display digit 1).

Function
REQ-018 SHALL pass rows through a 2-flop synchronizer; every row decision below uses the synchronized value only.
REQ-019 SHALL implement four states: SCAN, DEBOUNCE, HELD, RELEASE.
REQ-020 SCAN: SHALL drive column col_idx low for SCAN_CYCLES cycles, then sample rows on the last dwell cycle.
- If any row reads low: SHALL lock col_idx and the lowest-index low row, clear the counter, and go to DEBOUNCE.
- Otherwise: SHALL advance col_idx, wrapping NCOLS-1 -> 0.
REQ-021 DEBOUNCE: SHALL hold the locked column driven and increment the counter each cycle the locked row reads low.
- If the locked row reads high: SHALL return to SCAN and restart the dwell on the same column, with no event.
- When the counter reaches DEBOUNCE_CYCLES-1: SHALL go to HELD.
REQ-022 On the DEBOUNCE->HELD transition SHALL, in the same cycle, pulse key_valid=1 with key_repeat=0, set key_code to the new code, set last_key to the new code, and set prev_key to the old last_key.
REQ-023 HELD: key_held SHALL be 1, and all other keys SHALL be ignored (no rollover, no second event).
- When the locked row reads high: SHALL clear the counter and go to RELEASE.
REQ-024 When REPEAT_EN=1, HELD SHALL pulse key_valid with key_repeat=1 every REPEAT_CYCLES cycles, counted from HELD entry.
- Repeats SHALL update key_code only, not last_key or prev_key.
- When REPEAT_EN=0, no repeat logic SHALL affect any output.
REQ-025 RELEASE: key_held SHALL remain 1.
- After DEBOUNCE_CYCLES consecutive high samples of the locked row: SHALL clear key_held and go to SCAN at column 0.
- Any low sample of the locked row: SHALL return to HELD with no new event; the repeat timer SHALL continue, not restart.
REQ-026 key_repeat SHALL be 0 whenever key_valid is 0.
REQ-027 key_code SHALL hold its value between events.
REQ-028 The press-to-event latency from a stable row change SHALL be at most 2 (sync) + NCOLS*SCAN_CYCLES + DEBOUNCE_CYCLES cycles.
REQ-029 Simultaneous press and release on the same cycle SHALL resolve by the state rules above; no event SHALL fire in SCAN or RELEASE.

Reset
REQ-030 While reset=1 at a clock edge, the block SHALL enter SCAN with col_idx=0, so that cols = all ones except bit 0 low.
REQ-031 Reset SHALL clear key_valid, key_repeat, key_held, key_code, last_key, prev_key and all counters, and SHALL set the synchronizer flops to all ones.
REQ-032 Reset asserted mid-DEBOUNCE, HELD or RELEASE SHALL abort the operation with no key_valid pulse.

Verification (defaults: 4x4, SCAN_CYCLES=4, DEBOUNCE_CYCLES=8)
REQ-033 The bench SHALL cover reset with no keys: cols=1110 after reset, then 1101, 1011, 0111, 1110, each lasting 4 cycles; all outputs 0.
REQ-034 The bench SHALL cover a press at row 1, col 2, held 500 cycles then released: exactly one key_valid; key_code=6, last_key=6, prev_key=0; key_held drops at most 2+8 cycles after release.
REQ-035 The bench SHALL cover a 3-cycle bounce on row 2, col 1: no key_valid, key_held stays 0, and scanning resumes.
REQ-036 The bench SHALL cover press/release of (1,2) then (2,1): key_code 6 then 9; final last_key=9, prev_key=6.
REQ-037 The bench SHALL cover holding (1,2) and then also pressing (3,2): no second event; after both are released, scanning resumes at column 0.
REQ-038 The bench SHALL cover REPEAT_EN=1 with (0,0) held 200 cycles: one event with key_repeat=0, then 3 events with key_repeat=1 spaced 64 cycles apart; last_key=0 and prev_key unchanged.
